// File: rtl/axis_majority_vote_n.sv
// N-way AXI-Stream bitwise majority voter: one FIFO per channel, a full vote when every head is present,
// and a forced vote over the present heads after TIMEOUT partial cycles. One output register stage.
module axis_majority_vote_n #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH     = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_CH-1:0]            s_axis_tvalid,
  output logic [NUM_CH-1:0]            s_axis_tready,
  input  logic [NUM_CH-1:0]            s_axis_tlast,
  output logic [DATA_WIDTH-1:0]        m_axis_tdata,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic                         m_axis_tlast,
  output logic [NUM_CH-1:0]            mismatch_mask,
  output logic                         vote_fail,
  output logic [15:0]                  err_count
);

  localparam int AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW     = AW + 1;
  localparam int HALF   = NUM_CH / 2;
  localparam int QUORUM = NUM_CH / 2 + 1;
  localparam int TW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMAX = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

  typedef enum logic {IDLE, PARTIAL} state_t;

  logic [DATA_WIDTH:0]   mem_q    [NUM_CH][FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q [NUM_CH];
  logic [AW-1:0]         rd_ptr_q [NUM_CH];
  logic [CW-1:0]         cnt_q    [NUM_CH];
  logic [3:0]            credit_q [NUM_CH];
  logic [DATA_WIDTH-1:0] head_dat [NUM_CH];
  logic [NUM_CH-1:0]     head_last;
  logic [NUM_CH-1:0]     head_v;
  logic [NUM_CH-1:0]     full;
  logic [NUM_CH-1:0]     accept;
  logic [NUM_CH-1:0]     push;
  logic [NUM_CH-1:0]     pop;
  logic [NUM_CH-1:0]     credit_inc;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            all_v, partial, slot_free, tmo_hit;
  logic            full_fire, tmo_fire, quorum, load, fail;
  int              present_cnt;

  logic [DATA_WIDTH-1:0] vote_dat;
  logic                  vote_last;
  logic [NUM_CH-1:0]     vote_mask;

  logic [DATA_WIDTH-1:0] m_dat_q;
  logic                  m_vld_q, m_last_q, vote_fail_q;
  logic [NUM_CH-1:0]     mask_q;
  logic [15:0]           err_count_q;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      head_v[i]        = (cnt_q[i] != '0);
      full[i]          = (cnt_q[i] == CW'(FIFO_DEPTH));
      head_dat[i]      = mem_q[i][rd_ptr_q[i]][DATA_WIDTH-1:0];
      head_last[i]     = mem_q[i][rd_ptr_q[i]][DATA_WIDTH];
      s_axis_tready[i] = !full[i] || (credit_q[i] != 4'd0);
      accept[i]        = s_axis_tvalid[i] && s_axis_tready[i];
      // A word arriving while the channel owes drop credit belongs to a round already voted.
      push[i]          = accept[i] && (credit_q[i] == 4'd0);
    end
  end

  always_comb begin
    present_cnt = 0;
    for (int i = 0; i < NUM_CH; i++)
      if (head_v[i]) present_cnt++;
  end

  assign all_v     = &head_v;
  assign partial   = (|head_v) && !all_v;
  assign slot_free = !m_vld_q || m_axis_tready;
  assign tmo_hit   = (TIMEOUT != 0) && partial && (timer_q == TMAX);
  assign full_fire = all_v && slot_free;
  assign tmo_fire  = tmo_hit && slot_free;
  assign quorum    = (present_cnt >= QUORUM);
  assign load      = full_fire || (tmo_fire && quorum);
  assign fail      = tmo_fire && !quorum;
  assign pop        = (full_fire || tmo_fire) ? head_v : '0;
  assign credit_inc = tmo_fire ? ~head_v : '0;

  // Absent channels never contribute ones, so the same threshold serves full and timeout votes.
  always_comb begin : p_vote
    int ones;
    ones      = 0;
    vote_dat  = '0;
    vote_last = 1'b0;
    for (int b = 0; b < DATA_WIDTH; b++) begin
      ones = 0;
      for (int i = 0; i < NUM_CH; i++)
        if (head_v[i] && head_dat[i][b]) ones++;
      vote_dat[b] = (ones > HALF);
    end
    ones = 0;
    for (int i = 0; i < NUM_CH; i++)
      if (head_v[i] && head_last[i]) ones++;
    vote_last = (ones > HALF);
    for (int i = 0; i < NUM_CH; i++)
      vote_mask[i] = !head_v[i] || (head_dat[i] != vote_dat) || (head_last[i] != vote_last);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = (partial && !tmo_fire) ? PARTIAL : IDLE;
  end

  // Timer holds at TMAX while a timeout waits for the output slot.
  always_comb begin
    timer_d = '0;
    if (state_d == PARTIAL)
      timer_d = (timer_q == TMAX) ? timer_q : timer_q + TW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) timer_q <= '0;
    else     timer_q <= timer_d;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++)
      if (push[i])
        mem_q[i][wr_ptr_q[i]] <= {s_axis_tlast[i], s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
        credit_q[i] <= 4'd0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + AW'(1);
        if (pop[i])  rd_ptr_q[i] <= rd_ptr_q[i] + AW'(1);
        cnt_q[i] <= cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
        if (credit_inc[i] && !(accept[i] && credit_q[i] != 4'd0)) begin
          if (credit_q[i] != 4'd15) credit_q[i] <= credit_q[i] + 4'd1;
        end else if (!credit_inc[i] && accept[i] && credit_q[i] != 4'd0) begin
          credit_q[i] <= credit_q[i] - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_dat_q     <= '0;
      m_last_q    <= 1'b0;
      mask_q      <= '0;
      m_vld_q     <= 1'b0;
      vote_fail_q <= 1'b0;
      err_count_q <= 16'd0;
    end else begin
      vote_fail_q <= fail;
      if (load) begin
        m_dat_q  <= vote_dat;
        m_last_q <= vote_last;
        mask_q   <= vote_mask;
        m_vld_q  <= 1'b1;
        if ((|vote_mask) && (err_count_q != 16'hFFFF)) err_count_q <= err_count_q + 16'd1;
      end else if (m_axis_tready) begin
        m_vld_q <= 1'b0;
      end
    end
  end

  assign m_axis_tdata  = m_dat_q;
  assign m_axis_tvalid = m_vld_q;
  assign m_axis_tlast  = m_last_q;
  assign mismatch_mask = mask_q;
  assign vote_fail     = vote_fail_q;
  assign err_count     = err_count_q;

endmodule

// File: doc/axis_majority_vote_n.md
# axis_majority_vote_n

Parametrised N-way AXI-Stream majority voter that follows the ensemble stage and replaces the fixed 3-input voter. Each input channel has its own FIFO. When every channel holds a word, the block forms a bitwise majority. When some channels stall, a timeout votes over the channels present and drops their late words afterwards. It emits one voted word per round, together with a mismatch mask, so downstream logic can identify the faulty ensemble member.

## Interface
- DATA_WIDTH, 32: bits per word on every channel.
- NUM_CH, 3: number of voted channels. Odd, 3..7.
- FIFO_DEPTH, 4: per-channel FIFO entries. Power of two, ≥2.
- TIMEOUT, 64: cycles a partial round may wait before a forced vote. 0 disables the timeout.
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- s_axis_tdata  in  NUM_CH*DATA_WIDTH  channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- s_axis_tvalid  in  NUM_CH  per-channel valid.
- s_axis_tready  out  NUM_CH  per-channel ready.
- s_axis_tlast  in  NUM_CH  per-channel last.
- m_axis_tdata  out  DATA_WIDTH  voted word.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- m_axis_tlast  out  1  majority of the tlast bits.
- mismatch_mask  out  NUM_CH  bit i set when channel i differed from the voted word or was absent. Valid with m_axis_tvalid.
- vote_fail  out  1  one-cycle pulse: timeout fired without quorum.
- err_count  out  16  saturating count of emitted words with a nonzero mismatch_mask.

## Operation
- **Input accept (channel i):**
  - Push when s_axis_tvalid[i] && s_axis_tready[i] and drop_credit[i]==0.
  - s_axis_tready[i] = !full[i] || drop_credit[i]!=0.
- **Drop credit:** a 4-bit per-channel counter, saturating at 15.
  - Increments when channel i is absent from a timeout round.
  - While nonzero, an accepted word on channel i is discarded (not written) and the credit decrements.
  - Increment and decrement in the same cycle leave the credit unchanged.
- **Head state:** head_v[i] = FIFO i not empty. QUORUM = NUM_CH/2+1.
- **Controller states:**
  - IDLE: no head valid. Timer is 0.
  - PARTIAL: at least one head valid but not all. Timer increments each cycle.
  - Return to IDLE when heads become all-valid or none-valid.
- **Full vote:** all head_v set and the output slot free. The output slot is free when m_axis_tvalid is 0 or m_axis_tready is 1.
  - Bit b of the result is 1 when the count of ones across channels exceeds NUM_CH/2.
  - tlast is voted the same way.
  - All heads pop.
- **Timeout vote:** in PARTIAL with timer == TIMEOUT-1 and the output slot free.
  - Present count ≥ QUORUM: vote over present heads with the same threshold (ones > NUM_CH/2). Absent channels are flagged in mismatch_mask and gain drop credit. Present heads pop.
  - Present count < QUORUM: no output; vote_fail pulses, present heads pop, absent channels gain credit.
  - The timer clears in both cases.
  - If the output slot is busy at timeout, the timer holds at TIMEOUT-1 until the slot frees.
- **Counters and mask:**
  - err_count increments when a registered output has a nonzero mask; it saturates at 0xFFFF.
  - A mask bit is set when the channel's head differs from the voted word in any data bit or in tlast.
- **Output register:** one stage. It holds data, last and mask stable while m_axis_tvalid && !m_axis_tready.

## Timing
- **Reset values:** s_axis_tready all 1; m_axis_tvalid 0; m_axis_tdata 0; m_axis_tlast 0; mismatch_mask 0; vote_fail 0; err_count 0. Reset also clears FIFOs, credits and timer, and places the controller in IDLE.
- **Reset mid-round:** asynchronous assertion drops all buffered and in-flight data immediately.
- **Latency:** the last channel's word is accepted at edge E. The vote registers at edge E+1, so m_axis_tvalid is high from E+1. This assumes the output slot is free.
- **Throughput:** one vote per cycle under continuous tvalid and tready.
- **Back-to-back output:** when the register is valid and m_axis_tready=1, a new vote loads at the same edge with no bubble.
- **FIFO full:** tready deasserts combinationally from the registered count. No write occurs when full, even if a pop happens in the same cycle.
- **FIFO empty:** a push and a pop in the same cycle are legal only when head_v was already set.
- **Wrap-around:** pointers are log2(FIFO_DEPTH) bits wide and wrap naturally.
- **Timeout timing:** vote_fail asserts at edge E_t+1, where E_t is the edge of the timeout cycle, and stays high for exactly one cycle.

## Test plan
- **Unanimous:** NUM_CH=3, all channels send 0xFFFFFFFF with tlast=1 at edge E → m_axis_tdata=0xFFFFFFFF, tlast=1, mask=000 and m_axis_tvalid from E+1.
- **Single fault:** channels 0 and 1 send 0xA5A5A5A5, channel 2 sends 0x00000000 → output 0xA5A5A5A5, mask=100, err_count=1.
- **Timeout with quorum:** TIMEOUT=8, channels 0 and 1 send 0x12345678, channel 2 is silent → output 0x12345678 on the 8th cycle of PARTIAL, mask=100, drop_credit[2]=1. A later word on channel 2 is consumed and discarded, and the next full round stays aligned.
- **Timeout without quorum:** NUM_CH=5, only channel 0 sends → vote_fail pulses once, no output word, credits of channels 1-4 become 1.
- **Backpressure:** hold m_axis_tready=0 while FIFO_DEPTH+1 words arrive per channel → s_axis_tready drops after 4 words plus 1 in the output register. Release gives 5 words in order with no loss and no duplication.
- **Reset mid-stream:** assert rst with 2 words buffered → all outputs at reset values immediately; after release, the first new round votes correctly.
